// File: rtl/alu_rr_sequencer_if.sv
// Request, ALU and response signals of the shared-ALU sequencer.
// slave = the sequencer; master = issue logic, ALU and response consumer.
interface alu_rr_sequencer_if;
  logic       req0_valid;
  logic [3:0] req0_op;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic       req0_ready;

  logic       req1_valid;
  logic [3:0] req1_op;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic       req1_ready;

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_f;
  logic       alu_c;
  logic       alu_z;
  logic       alu_o;
  logic       alu_g;
  logic       alu_l;
  logic       alu_e;

  logic       resp_valid;
  logic       resp_ready;
  logic       resp_id;
  logic [7:0] resp_data;
  logic [5:0] resp_flags;
  logic       resp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_f, alu_c, alu_z, alu_o, alu_g, alu_l, alu_e,
    output resp_valid, resp_id, resp_data, resp_flags, resp_err,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_f, alu_c, alu_z, alu_o, alu_g, alu_l, alu_e,
    input  resp_valid, resp_id, resp_data, resp_flags, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/alu_rr_sequencer.sv
// Shares one 8-bit ALU between two requesters with round-robin arbitration.
//
// state | meaning
// IDLE  | waiting for a request; ready asserted to the granted requester
// ISSUE | ALU inputs stable; combinational flags captured
// WAIT  | counting down the ALU result latency; F captured at zero
// RESP  | response held on the response channel until resp_ready
module alu_rr_sequencer #(
  parameter int ALU_LAT = 1,
  parameter int NUM_OPS = 11
) (
  input logic clk,
  input logic rst,
  alu_rr_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT_M1    = 3'(ALU_LAT - 1);
  localparam logic [4:0] NUM_OPS_W = 5'(NUM_OPS);

  state_t     state, state_nxt;
  logic       last_grant;
  logic [2:0] cnt;
  logic [5:0] flags_q;

  logic       gnt0, gnt1, accept, gnt_id, gnt_legal;
  logic [3:0] gnt_op;
  logic [7:0] gnt_a, gnt_b;

  // Round-robin grant: only in IDLE, and never while reset is held
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign accept    = gnt0 | gnt1;
  assign gnt_id    = gnt1;
  assign gnt_op    = gnt1 ? bus.req1_op : bus.req0_op;
  assign gnt_a     = gnt1 ? bus.req1_a  : bus.req0_a;
  assign gnt_b     = gnt1 ? bus.req1_b  : bus.req0_b;
  assign gnt_legal = ({1'b0, gnt_op} < NUM_OPS_W);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; illegal opcodes skip the ALU entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = gnt_legal ? ISSUE : RESP;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 3'd0) state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs derived from state and grant
  always_comb begin
    bus.req0_ready = gnt0;
    bus.req1_ready = gnt1;
    bus.resp_valid = (state == RESP);
  end

  // Datapath: operand/select registers, flag capture, latency counter, response
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant     <= 1'b1;
      cnt            <= 3'd0;
      flags_q        <= 6'd0;
      bus.alu_a      <= 8'd0;
      bus.alu_b      <= 8'd0;
      bus.alu_sel    <= 4'd0;
      bus.resp_id    <= 1'b0;
      bus.resp_data  <= 8'd0;
      bus.resp_flags <= 6'd0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant  <= gnt_id;
            bus.resp_id <= gnt_id;
            if (gnt_legal) begin
              bus.alu_a   <= gnt_a;
              bus.alu_b   <= gnt_b;
              bus.alu_sel <= gnt_op;
            end else begin
              bus.resp_err   <= 1'b1;
              bus.resp_data  <= 8'd0;
              bus.resp_flags <= 6'd0;
            end
          end
        end
        ISSUE: begin
          flags_q <= {bus.alu_c, bus.alu_z, bus.alu_o, bus.alu_g, bus.alu_l, bus.alu_e};
          cnt     <= LAT_M1;
        end
        WAIT: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            bus.resp_data  <= bus.alu_f;
            bus.resp_flags <= flags_q;
            bus.resp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer: a LAT=1 instance with a response
// scoreboard, and a LAT=3 instance for reset-during-WAIT behaviour.
module tb_alu_rr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_l3;

  alu_rr_sequencer_if ifa ();
  alu_rr_sequencer_if ifb ();

  alu_rr_sequencer #(.ALU_LAT(1), .NUM_OPS(11)) dut_a (.clk(clk), .rst(rst_a),  .bus(ifa));
  alu_rr_sequencer #(.ALU_LAT(3), .NUM_OPS(11)) dut_b (.clk(clk), .rst(rst_l3), .bus(ifb));

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic [5:0] flags;
    logic       err;
  } rsp_t;

  rsp_t sb[$];
  logic gq[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  // Reference ALU: returns {F, c, z, o, g, l, e}
  function automatic logic [13:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, o;
    c = 1'b0;
    o = 1'b0;
    r = 8'd0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin r = a - b; c = (a < b); o = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: begin r = ~b + 8'd1; o = (b == 8'h80); end
      4'd3: r = a & b;
      4'd4: r = a ^ b;
      4'd5: r = a | b;
      4'd6: r = ~a;
      4'd7: begin r = {a[0], a[7:1]}; c = a[0]; end
      4'd8: begin r = {a[6:0], a[7]}; c = a[7]; end
      4'd9: begin r = {1'b0, a[7:1]}; c = a[0]; end
      4'd10: begin r = {a[6:0], 1'b0}; c = a[7]; end
      default: r = 8'd0;
    endcase
    return {r, c, (r == 8'd0), o, (a > b), (a < b), (a == b)};
  endfunction

  function automatic rsp_t exp_rsp(input logic id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    rsp_t       r;
    logic [13:0] v;
    r.id = id;
    if (op >= 4'd11) begin
      r.data = 8'd0; r.flags = 6'd0; r.err = 1'b1;
    end else begin
      v = alu_fn(op, a, b);
      r.data = v[13:6]; r.flags = v[5:0]; r.err = 1'b0;
    end
    return r;
  endfunction

  // ALU models: combinational flags, F registered ALU_LAT times
  logic [13:0] fa_now, fb_now;
  logic [7:0]  fb_p1, fb_p2;
  assign fa_now = alu_fn(ifa.alu_sel, ifa.alu_a, ifa.alu_b);
  assign fb_now = alu_fn(ifb.alu_sel, ifb.alu_a, ifb.alu_b);

  always_comb begin
    {ifa.alu_c, ifa.alu_z, ifa.alu_o, ifa.alu_g, ifa.alu_l, ifa.alu_e} = fa_now[5:0];
    {ifb.alu_c, ifb.alu_z, ifb.alu_o, ifb.alu_g, ifb.alu_l, ifb.alu_e} = fb_now[5:0];
  end

  always @(posedge clk) begin
    ifa.alu_f <= fa_now[13:6];
    fb_p1     <= fb_now[13:6];
    fb_p2     <= fb_p1;
    ifb.alu_f <= fb_p2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tot++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle monitor for instance A: scoreboard push on accept, pop on response
  task automatic mon();
    rsp_t got, e;
    @(negedge clk);
    if (!rst_a) begin
      if (ifa.req0_ready || ifa.req1_ready)
        chk("one_ready", 32'(ifa.req0_ready & ifa.req1_ready), 32'd0);
      if (ifa.req0_ready) begin
        sb.push_back(exp_rsp(1'b0, ifa.req0_op, ifa.req0_a, ifa.req0_b));
        gq.push_back(1'b0);
      end
      if (ifa.req1_ready) begin
        sb.push_back(exp_rsp(1'b1, ifa.req1_op, ifa.req1_a, ifa.req1_b));
        gq.push_back(1'b1);
      end
      if (ifa.resp_valid && ifa.resp_ready) begin
        chk("sb_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e   = sb.pop_front();
          got = {ifa.resp_id, ifa.resp_data, ifa.resp_flags, ifa.resp_err};
          chk("resp_sb", 32'(got), 32'(e));
        end
      end
    end
  endtask

  task automatic wait_resp(input int budget);
    int k;
    k = 0;
    while (!ifa.resp_valid && k < budget) begin
      nxt();
      mon();
      k++;
    end
    chk("resp_timeout", 32'(ifa.resp_valid), 32'd1);
  endtask

  initial begin
    int   bad, k;
    rsp_t eb, gb;

    rst_a = 1'b1;
    rst_l3 = 1'b1;
    ifa.req0_valid = 0; ifa.req0_op = 0; ifa.req0_a = 0; ifa.req0_b = 0;
    ifa.req1_valid = 0; ifa.req1_op = 0; ifa.req1_a = 0; ifa.req1_b = 0;
    ifa.resp_ready = 1;
    ifb.req0_valid = 0; ifb.req0_op = 0; ifb.req0_a = 0; ifb.req0_b = 0;
    ifb.req1_valid = 0; ifb.req1_op = 0; ifb.req1_a = 0; ifb.req1_b = 0;
    ifb.resp_ready = 1;

    repeat (2) nxt();
    @(negedge clk);
    chk("rst_alu", 32'({ifa.alu_a, ifa.alu_b, ifa.alu_sel}), 32'd0);
    chk("rst_resp", 32'({ifa.resp_valid, ifa.resp_id, ifa.resp_data, ifa.resp_flags,
                         ifa.resp_err, ifa.req0_ready, ifa.req1_ready}), 32'd0);
    nxt();

    // add from requester 0 right after reset release
    rst_a = 1'b0;
    ifa.req0_valid = 1; ifa.req0_op = 4'd0; ifa.req0_a = 8'h0F; ifa.req0_b = 8'h01;
    mon();
    chk("t1_ready0", 32'(ifa.req0_ready), 32'd1);
    nxt(); ifa.req0_valid = 0;
    mon();
    chk("t1_alu_a", 32'(ifa.alu_a), 32'h0F);
    chk("t1_c1_idle", 32'(ifa.resp_valid), 32'd0);
    nxt(); mon();
    chk("t1_c2_idle", 32'(ifa.resp_valid), 32'd0);
    nxt(); mon();
    chk("t1_c3_valid", 32'(ifa.resp_valid), 32'd1);
    chk("t1_id", 32'(ifa.resp_id), 32'd0);
    chk("t1_data", 32'(ifa.resp_data), 32'h10);
    chk("t1_cz", 32'(ifa.resp_flags[5:4]), 32'd0);
    nxt(); mon();
    chk("t1_done", 32'(ifa.resp_valid), 32'd0);
    nxt();

    // subtract to zero from requester 1
    ifa.req1_valid = 1; ifa.req1_op = 4'd1; ifa.req1_a = 8'h05; ifa.req1_b = 8'h05;
    mon();
    chk("t2_ready1", 32'(ifa.req1_ready), 32'd1);
    nxt(); ifa.req1_valid = 0;
    mon();
    wait_resp(8);
    chk("t2_id", 32'(ifa.resp_id), 32'd1);
    chk("t2_data", 32'(ifa.resp_data), 32'h00);
    chk("t2_z", 32'(ifa.resp_flags[4]), 32'd1);
    chk("t2_e", 32'(ifa.resp_flags[0]), 32'd1);
    nxt();

    // both requesters continuously valid: grants must alternate
    gq.delete();
    ifa.req0_valid = 1; ifa.req0_op = 4'd3; ifa.req0_a = 8'hF0; ifa.req0_b = 8'h3C;
    ifa.req1_valid = 1; ifa.req1_op = 4'd5; ifa.req1_a = 8'h0F; ifa.req1_b = 8'h30;
    repeat (16) begin mon(); nxt(); end
    ifa.req0_valid = 0; ifa.req1_valid = 0;
    repeat (6) begin mon(); nxt(); end
    chk("t3_ngrant", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t3_order", 32'(gq[i]), 32'(i % 2));
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // illegal opcode: immediate error response, ALU registers untouched
    ifa.req0_valid = 1; ifa.req0_op = 4'hC; ifa.req0_a = 8'hAA; ifa.req0_b = 8'h55;
    mon();
    chk("t4_ready0", 32'(ifa.req0_ready), 32'd1);
    nxt(); ifa.req0_valid = 0;
    mon();
    chk("t4_valid", 32'(ifa.resp_valid), 32'd1);
    chk("t4_err", 32'(ifa.resp_err), 32'd1);
    chk("t4_data", 32'(ifa.resp_data), 32'd0);
    chk("t4_sel", 32'(ifa.alu_sel), 32'd5);
    chk("t4_alu_a", 32'(ifa.alu_a), 32'h0F);
    nxt();

    // backpressure in RESP with both requesters pending
    ifa.resp_ready = 0;
    ifa.req1_valid = 1; ifa.req1_op = 4'd8; ifa.req1_a = 8'h81; ifa.req1_b = 8'h00;
    mon();
    chk("t5_ready1", 32'(ifa.req1_ready), 32'd1);
    nxt();
    ifa.req1_op = 4'd1; ifa.req1_a = 8'h10; ifa.req1_b = 8'h01;
    ifa.req0_valid = 1; ifa.req0_op = 4'd4; ifa.req0_a = 8'h3C; ifa.req0_b = 8'hFF;
    mon();
    wait_resp(8);
    chk("t5_data", 32'(ifa.resp_data), 32'h03);
    bad = 0;
    repeat (10) begin
      nxt(); mon();
      if (!(ifa.resp_valid && ifa.resp_data == 8'h03 && !ifa.req0_ready && !ifa.req1_ready))
        bad++;
    end
    chk("t5_hold", 32'(bad), 32'd0);
    nxt(); ifa.resp_ready = 1;
    mon();
    nxt(); mon();
    chk("t5_idle_r0", 32'(ifa.req0_ready), 32'd1);
    chk("t5_idle_r1", 32'(ifa.req1_ready), 32'd0);
    nxt(); ifa.req0_valid = 0; ifa.req1_valid = 0;
    repeat (6) begin mon(); nxt(); end
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // ALU_LAT=3 instance: reset asserted during WAIT abandons the op
    rst_l3 = 1'b0;
    ifb.req0_valid = 1; ifb.req0_op = 4'd0; ifb.req0_a = 8'h01; ifb.req0_b = 8'h02;
    @(negedge clk);
    chk("b_ready0", 32'(ifb.req0_ready), 32'd1);
    nxt(); ifb.req0_valid = 0;
    nxt();
    nxt();
    rst_l3 = 1'b1;
    nxt();
    @(negedge clk);
    chk("b_rst_alu", 32'({ifb.alu_a, ifb.alu_b, ifb.alu_sel}), 32'd0);
    chk("b_rst_resp", 32'({ifb.resp_valid, ifb.resp_id, ifb.resp_data, ifb.resp_flags,
                           ifb.resp_err, ifb.req0_ready, ifb.req1_ready}), 32'd0);
    nxt(); rst_l3 = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (ifb.resp_valid) bad++;
      nxt();
    end
    chk("b_no_resp", 32'(bad), 32'd0);

    ifb.req0_valid = 1; ifb.req0_op = 4'd4; ifb.req0_a = 8'hF0; ifb.req0_b = 8'h0F;
    ifb.req1_valid = 1; ifb.req1_op = 4'd3; ifb.req1_a = 8'h12; ifb.req1_b = 8'h34;
    @(negedge clk);
    chk("b_grant_r0", 32'(ifb.req0_ready), 32'd1);
    chk("b_grant_r1", 32'(ifb.req1_ready), 32'd0);
    eb = exp_rsp(1'b0, 4'd4, 8'hF0, 8'h0F);
    nxt(); ifb.req0_valid = 0; ifb.req1_valid = 0;
    @(negedge clk);
    k = 1;
    while (!ifb.resp_valid && k < 12) begin
      nxt();
      @(negedge clk);
      k++;
    end
    chk("b_latency", 32'(k), 32'd5);
    gb = {ifb.resp_id, ifb.resp_data, ifb.resp_flags, ifb.resp_err};
    chk("b_resp", 32'(gb), 32'(eb));
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/alu_rr_sequencer.md
Name: alu_rr_sequencer

Overview:
- Controller that shares the 8-bit ALU between two requesters using round-robin arbitration and valid/ready handshakes.
- For each accepted request it drives the ALU operands and select lines, and waits the ALU's registered-result latency.
- It then returns the result, the carry/zero/overflow flags and the compare flags to the requester on a single response channel.
- It sits between the instruction-issue logic and the ALU top.

Parameters:
- ALU_LAT, 1: cycles from ALU inputs stable to F valid (result register); legal range 1..7.
- NUM_OPS, 11: number of legal opcodes (0..NUM_OPS-1); all others are illegal.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an op
- req0_op  in  4  opcode; maps directly to {S3,S2,S1,S0}
- req0_a  in  8  operand A
- req0_b  in  8  operand B
- req0_ready  out  1  request accepted this cycle
- req1_valid / req1_op / req1_a / req1_b / req1_ready: same as requester 0, for requester 1
- alu_a  out  8  ALU operand A (registered)
- alu_b  out  8  ALU operand B (registered)
- alu_sel  out  4  ALU select {S3,S2,S1,S0} (registered)
- alu_f  in  8  ALU registered result F
- alu_c, alu_z, alu_o  in  1 each  ALU combinational flags
- alu_g, alu_l, alu_e  in  1 each  ALU compare outputs
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  requester index of the response
- resp_data  out  8  result
- resp_flags  out  6  {c,z,o,g,l,e}
- resp_err  out  1  illegal opcode

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; last_grant=1, so requester 0 wins first.
  - All outputs 0: alu_a, alu_b, alu_sel, resp_*, req*_ready.
  - Any in-flight op is abandoned; no response is emitted for it.
- Opcode map (alu_sel=op): 0 add, 1 sub, 2 two's-complement of B, 3 and, 4 xor, 5 or, 6 one's-complement of A, 7 rotate right, 8 rotate left, 9 shift right, 10 shift left. Opcodes 11..15 are illegal.
- IDLE:
  - If any reqN_valid=1, grant one requester.
  - Both valid: grant the requester that is not last_grant. One valid: grant that requester.
  - reqN_ready=1 combinationally in this cycle, granted requester only; it is 0 in every other state.
  - On the accepting edge: latch id, op, a, b; update last_grant.
  - Legal op: load alu_a, alu_b, alu_sel; go to ISSUE.
  - Illegal op: go to RESP with resp_err=1, resp_data=0, resp_flags=0. The alu_* registers are unchanged.
- ISSUE (1 cycle):
  - ALU inputs are stable.
  - Capture alu_c/z/o/g/l/e into a flag register; the flags are combinational and align with this cycle.
  - Load wait counter with ALU_LAT-1; go to WAIT.
- WAIT:
  - While counter≠0, decrement it.
  - At counter=0: capture alu_f into resp_data, drive resp_flags from the flag register, resp_err=0; go to RESP.
  - WAIT lasts exactly ALU_LAT cycles.
- RESP:
  - resp_valid=1, with resp_id, resp_data, resp_flags and resp_err held stable until resp_ready=1.
  - On the handshake edge: resp_valid→0, go to IDLE.
  - The next request is not accepted in the same cycle as the response handshake.
- alu_a, alu_b, alu_sel change only on an accept edge of a legal op; they hold through ISSUE, WAIT and RESP.
- Latency, legal op, ALU_LAT=1: accept at edge t, ISSUE in cycle t+1, WAIT in cycle t+2, resp_valid=1 from cycle t+3.
- Throughput: one op per ALU_LAT+3 cycles minimum.
- A requester must hold valid, op, a and b stable until ready. Deasserting valid before the grant simply withdraws the request.
- Backpressure: resp_ready=0 holds the block in RESP indefinitely; both readys stay 0.

Test Plan:
- Reset, then req0 op=0 A=8'h0F B=8'h01 → req0_ready in cycle 0 after reset release; resp_valid in cycle 3 with resp_id=0, resp_data=8'h10, c=0, z=0.
- req1 op=1 A=8'h05 B=8'h05 → resp_data=8'h00, z=1, e=1, resp_id=1.
- Both requesters valid continuously, resp_ready=1 → grants alternate 0,1,0,1; no requester is granted twice in a row.
- req0 op=4'hC → response after 1 cycle with resp_err=1, resp_data=0; alu_sel unchanged from the previous legal op.
- resp_ready=0 for 10 cycles during RESP → resp_valid and resp_data stable, req0_ready=req1_ready=0; release → IDLE next cycle.
- ALU_LAT=3 build, rst asserted during WAIT → next cycle all outputs 0, no response; a subsequent request is granted to req0.
